slave_port_v1: RTL and testbench

- Bus-side responder for the serial system bus; it is the counterpart of the master port.
- It deserialises the slave memory address and, for writes, the write data from the bus.
- It issues one parallel request to the attached slave memory/device over a valid/ready handshake.
- For reads, it serialises the returned data back onto the bus with svalid framing.
- One instance sits between the bus mux/decoder and each slave device.

---
 rtl/slave_port_v1_pkg.sv | 29 ++
 rtl/slave_port_v1_if.sv | 40 ++++
 rtl/slave_port_v1.sv | 165 ++++++++++++++++
 tb/tb_slave_port_v1.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/slave_port_v1_pkg.sv
// Shared serial-bus definitions: bus geometry, transfer mode codes, slave-port state encoding.
// Pure definitions; no logic, no latency.
// Imported by the slave port and its bus interface.
package slave_port_v1_pkg;

  localparam int BUS_ADDR_WIDTH   = 16;
  localparam int SLAVE_ADDR_WIDTH = 4;
  localparam int BUS_DATA_WIDTH   = 8;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    WDATA = 3'd2,
    DREQ  = 3'd3,
    DWAIT = 3'd4,
    RDATA = 3'd5
  } sp_state_t;

  // Bit counter must reach the larger of the two field widths; one spare bit of headroom.
  function automatic int cnt_width(input int a, input int d);
    int m;
    m = (a > d) ? a : d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/slave_port_v1_if.sv
// Bundles the serial bus side and the parallel device side of one slave port.
// Wires only; no latency.
// Flow control is carried by mvalid/svalid/sready on the bus and dvalid/dready/drvalid on the device.
interface slave_port_v1_if
  import slave_port_v1_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH - SLAVE_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) ();

  // serial bus side
  logic                  swdata;
  logic                  smode;
  logic                  mvalid;
  logic                  srdata;
  logic                  svalid;
  logic                  sready;

  // parallel device side
  logic [ADDR_WIDTH-1:0] daddr;
  logic [DATA_WIDTH-1:0] dwdata;
  logic                  dmode;
  logic                  dvalid;
  logic                  dready;
  logic [DATA_WIDTH-1:0] drdata;
  logic                  drvalid;

  // the slave port itself
  modport slave (
    input  swdata, smode, mvalid, dready, drdata, drvalid,
    output srdata, svalid, sready, daddr, dwdata, dmode, dvalid
  );

  // whatever drives the bus and models the device
  modport master (
    output swdata, smode, mvalid, dready, drdata, drvalid,
    input  srdata, svalid, sready, daddr, dwdata, dmode, dvalid
  );

endinterface

// File: rtl/slave_port_v1.sv
// Serial-bus slave port: deserialises address/write data, issues one device request, serialises read data.
// Latency: dvalid 1 cycle after last serial bit sampled; first svalid 1 cycle after drvalid.
// Backpressure: dvalid held with stable payload until dready; serial input only taken while sready/ADDR/WDATA.
module slave_port_v1
  import slave_port_v1_pkg::*;
#(
  parameter int ADDR_WIDTH = BUS_ADDR_WIDTH - SLAVE_ADDR_WIDTH,
  parameter int DATA_WIDTH = BUS_DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  slave_port_v1_if.slave   bus
);

  localparam int             CNT_W     = cnt_width(ADDR_WIDTH, DATA_WIDTH);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  sp_state_t             state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata, wdata_nxt;
  logic [DATA_WIDTH-1:0] rdata, rdata_nxt;
  logic [DATA_WIDTH-1:0] rshift;
  logic                  mode, mode_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  srdata_nxt;

  // The port is free exactly when idle; this is the only unregistered output.
  assign bus.sready = (state == IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus next values of the shift registers and bit counter.
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr;
    wdata_nxt  = wdata;
    rdata_nxt  = rdata;
    mode_nxt   = mode;
    cnt_nxt    = cnt;
    rshift     = '0;
    srdata_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (bus.mvalid) begin
          addr_nxt[0] = bus.swdata;
          mode_nxt    = bus.smode;
          if (ADDR_WIDTH == 1) begin
            cnt_nxt   = '0;
            state_nxt = (bus.smode == WRITE) ? WDATA : DREQ;
          end else begin
            cnt_nxt   = CNT_ONE;
            state_nxt = ADDR;
          end
        end
      end

      ADDR: begin
        if (bus.mvalid) begin
          addr_nxt = (addr & ~(ADDR_WIDTH'(1) << cnt)) | (ADDR_WIDTH'(bus.swdata) << cnt);
          if (cnt == ADDR_LAST) begin
            cnt_nxt   = '0;
            state_nxt = (mode == WRITE) ? WDATA : DREQ;
          end else begin
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
      end

      WDATA: begin
        if (bus.mvalid) begin
          wdata_nxt = (wdata & ~(DATA_WIDTH'(1) << cnt)) | (DATA_WIDTH'(bus.swdata) << cnt);
          if (cnt == DATA_LAST) begin
            cnt_nxt   = '0;
            state_nxt = DREQ;
          end else begin
            cnt_nxt   = cnt + CNT_ONE;
          end
        end
      end

      DREQ: begin
        if (bus.dready) begin
          if (mode == WRITE) begin
            state_nxt = IDLE;
          end else if (bus.drvalid) begin
            // device answered in the same cycle it accepted: skip the wait
            rdata_nxt = bus.drdata;
            cnt_nxt   = '0;
            state_nxt = RDATA;
          end else begin
            state_nxt = DWAIT;
          end
        end
      end

      DWAIT: begin
        if (bus.drvalid) begin
          rdata_nxt = bus.drdata;
          cnt_nxt   = '0;
          state_nxt = RDATA;
        end
      end

      RDATA: begin
        if (cnt == DATA_LAST) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Serial read bit is registered, so pick it from the next-cycle data and counter.
    rshift     = rdata_nxt >> cnt_nxt;
    srdata_nxt = (state_nxt == RDATA) && rshift[0];
  end

  // Datapath registers and registered outputs, all cleared by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr       <= '0;
      wdata      <= '0;
      rdata      <= '0;
      mode       <= 1'b0;
      cnt        <= '0;
      bus.daddr  <= '0;
      bus.dwdata <= '0;
      bus.dmode  <= 1'b0;
      bus.dvalid <= 1'b0;
      bus.svalid <= 1'b0;
      bus.srdata <= 1'b0;
    end else begin
      addr       <= addr_nxt;
      wdata      <= wdata_nxt;
      rdata      <= rdata_nxt;
      mode       <= mode_nxt;
      cnt        <= cnt_nxt;
      bus.dvalid <= (state_nxt == DREQ);
      bus.svalid <= (state_nxt == RDATA);
      bus.srdata <= srdata_nxt;
      // payload is loaded on entry to DREQ and cannot change while the request is pending
      if (state_nxt == DREQ) begin
        bus.daddr  <= addr_nxt;
        bus.dwdata <= wdata_nxt;
        bus.dmode  <= mode_nxt;
      end
    end
  end

endmodule

// File: tb/tb_slave_port_v1.sv
// Directed bench for slave_port_v1: table of transfers plus reset and back-to-back corners.
// Inputs driven 1ns after the rising edge, outputs checked 1ns after the rising edge.
// Device acceptance is logged independently and compared with the expected request order.
module tb_slave_port_v1;

  localparam int AW = 12;
  localparam int DW = 8;

  typedef struct {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            addr_gap_bit;
    int            addr_gap_len;
    int            data_gap_bit;
    int            data_gap_len;
    int            dready_delay;
    int            drvalid_delay;
    int            abort_bit;
    logic [AW-1:0] exp_daddr;
    logic [DW-1:0] exp_dwdata;
    logic          exp_dmode;
    logic [DW-1:0] exp_bits;
  } vec_t;

  typedef struct packed {
    logic          mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  req_t got_q[$];
  req_t exp_q[$];
  vec_t vecs[9];

  slave_port_v1_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

  slave_port_v1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record every accepted device request
  always @(posedge clk) begin
    if (rstn && bus_if.dvalid && bus_if.dready) begin
      got_q.push_back('{bus_if.dmode, bus_if.daddr, (bus_if.dmode ? bus_if.dwdata : 8'h00)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus_if.mvalid = 1'b1;
    bus_if.swdata = b;
    step();
    bus_if.mvalid = 1'b0;
    bus_if.swdata = 1'b0;
  endtask

  task automatic check_payload(input vec_t v, input string tag);
    check({tag, "_dvalid"}, 32'(bus_if.dvalid), 32'd1);
    check({tag, "_daddr"},  32'(bus_if.daddr),  32'(v.exp_daddr));
    check({tag, "_dmode"},  32'(bus_if.dmode),  32'(v.exp_dmode));
    if (v.mode) check({tag, "_dwdata"}, 32'(bus_if.dwdata), 32'(v.exp_dwdata));
  endtask

  task automatic do_txn(input vec_t v);
    bit aborted;
    aborted = 1'b0;
    check("start_sready", 32'(bus_if.sready), 32'd1);
    bus_if.smode = v.mode;

    for (int i = 0; i < AW; i++) begin
      send_bit(v.addr[i]);
      if (i == v.addr_gap_bit) begin
        for (int g = 0; g < v.addr_gap_len; g++) begin
          step();
          check("addr_gap_dvalid", 32'(bus_if.dvalid), 32'd0);
          check("addr_gap_sready", 32'(bus_if.sready), 32'd0);
        end
      end
    end
    if (v.mode) begin
      check("wdata_phase_dvalid", 32'(bus_if.dvalid), 32'd0);
      for (int i = 0; i < DW; i++) begin
        send_bit(v.wdata[i]);
        if (i == v.data_gap_bit) begin
          for (int g = 0; g < v.data_gap_len; g++) begin
            step();
            check("data_gap_dvalid", 32'(bus_if.dvalid), 32'd0);
          end
        end
      end
    end

    check_payload(v, "req");
    exp_q.push_back('{v.exp_dmode, v.exp_daddr, (v.mode ? v.exp_dwdata : 8'h00)});

    for (int k = 0; k < v.dready_delay; k++) begin
      step();
      check_payload(v, "bp");
    end

    bus_if.dready = 1'b1;
    if (!v.mode && v.drvalid_delay < 0) begin
      bus_if.drvalid = 1'b1;
      bus_if.drdata  = v.rdata;
    end
    step();
    bus_if.dready  = 1'b0;
    bus_if.drvalid = 1'b0;
    bus_if.drdata  = '0;
    check("accept_dvalid_drop", 32'(bus_if.dvalid), 32'd0);

    if (v.mode) begin
      check("wr_svalid", 32'(bus_if.svalid), 32'd0);
      check("wr_sready", 32'(bus_if.sready), 32'd1);
    end else begin
      if (v.drvalid_delay >= 0) begin
        check("dwait_sready", 32'(bus_if.sready), 32'd0);
        for (int k = 0; k < v.drvalid_delay; k++) begin
          step();
          check("dwait_svalid", 32'(bus_if.svalid), 32'd0);
        end
        bus_if.drvalid = 1'b1;
        bus_if.drdata  = v.rdata;
        step();
        bus_if.drvalid = 1'b0;
        bus_if.drdata  = '0;
      end
      for (int j = 0; j < DW; j++) begin
        if (!aborted) begin
          check("rd_svalid", 32'(bus_if.svalid), 32'd1);
          check("rd_srdata", 32'(bus_if.srdata), 32'(v.exp_bits[j]));
          if (j == v.abort_bit) begin
            rstn = 1'b0;
            step();
            check("rst_svalid", 32'(bus_if.svalid), 32'd0);
            check("rst_srdata", 32'(bus_if.srdata), 32'd0);
            check("rst_dvalid", 32'(bus_if.dvalid), 32'd0);
            check("rst_daddr",  32'(bus_if.daddr),  32'd0);
            check("rst_sready", 32'(bus_if.sready), 32'd1);
            rstn = 1'b1;
            aborted = 1'b1;
          end else begin
            step();
          end
        end
      end
      if (!aborted) begin
        check("rd_end_svalid", 32'(bus_if.svalid), 32'd0);
        check("rd_end_sready", 32'(bus_if.sready), 32'd1);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //            mode  addr     wdata  rdata  agb ag dgb dg drd drv abt  exp_daddr exp_dwd dmode exp_bits
    vecs[0] = '{1'b1, 12'hA5C, 8'h3C, 8'h00, -1, 0, -1, 0, 0,  0, -1, 12'hA5C, 8'h3C, 1'b1, 8'h00};
    vecs[1] = '{1'b0, 12'h123, 8'h00, 8'h96, -1, 0, -1, 0, 0,  3, -1, 12'h123, 8'h00, 1'b0, 8'b1001_0110};
    vecs[2] = '{1'b1, 12'h3C7, 8'h5A, 8'h00, -1, 0, -1, 0, 5,  0, -1, 12'h3C7, 8'h5A, 1'b1, 8'h00};
    vecs[3] = '{1'b1, 12'hA5C, 8'h3C, 8'h00,  5, 3,  2, 1, 0,  0, -1, 12'hA5C, 8'h3C, 1'b1, 8'h00};
    vecs[4] = '{1'b0, 12'h0FF, 8'h00, 8'hC3,  0, 2, -1, 0, 0, -1, -1, 12'h0FF, 8'h00, 1'b0, 8'b1100_0011};
    vecs[5] = '{1'b0, 12'h2F0, 8'h00, 8'h5A, -1, 0, -1, 0, 0,  1,  3, 12'h2F0, 8'h00, 1'b0, 8'b0101_1010};
    vecs[6] = '{1'b1, 12'h001, 8'hFF, 8'h00, -1, 0, -1, 0, 0,  0, -1, 12'h001, 8'hFF, 1'b1, 8'h00};
    vecs[7] = '{1'b1, 12'h010, 8'hAA, 8'h00, -1, 0, -1, 0, 0,  0, -1, 12'h010, 8'hAA, 1'b1, 8'h00};
    vecs[8] = '{1'b0, 12'h010, 8'h00, 8'hAA, -1, 0, -1, 0, 0,  0, -1, 12'h010, 8'h00, 1'b0, 8'b1010_1010};

    rstn           = 1'b0;
    bus_if.swdata  = 1'b0;
    bus_if.smode   = 1'b0;
    bus_if.mvalid  = 1'b0;
    bus_if.dready  = 1'b0;
    bus_if.drdata  = '0;
    bus_if.drvalid = 1'b0;
    repeat (3) step();

    check("reset_srdata", 32'(bus_if.srdata), 32'd0);
    check("reset_svalid", 32'(bus_if.svalid), 32'd0);
    check("reset_sready", 32'(bus_if.sready), 32'd1);
    check("reset_daddr",  32'(bus_if.daddr),  32'd0);
    check("reset_dwdata", 32'(bus_if.dwdata), 32'd0);
    check("reset_dmode",  32'(bus_if.dmode),  32'd0);
    check("reset_dvalid", 32'(bus_if.dvalid), 32'd0);

    rstn = 1'b1;
    repeat (2) step();
    check("idle_no_mvalid_sready", 32'(bus_if.sready), 32'd1);
    check("idle_no_mvalid_dvalid", 32'(bus_if.dvalid), 32'd0);

    // transfers run back to back: each starts the cycle after the previous returns to idle
    for (int n = 0; n < 9; n++) begin
      do_txn(vecs[n]);
    end

    repeat (2) step();
    check("req_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int n = 0; n < exp_q.size(); n++) begin
      if (n < got_q.size()) begin
        check($sformatf("req%0d", n), 32'(got_q[n]), 32'(exp_q[n]));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
